// File: rtl/ctrl_relu_fix.sv
// ctrl_relu_fix: sequencer for the two-layer fixed-point ReLU datapath.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   start        - begin one inference; only looked at in IDLE
//   arg_zero     - datapath flag: the argument just loaded equals 0
//   mem_addr     - read address for the weight/image memory
//   mem_rd       - read strobe; data returns one cycle later
//   r_sh_en      - shift enables: [0] ARG, [1] R1, [2] R2
//   mac_en       - MAC enables: [0] layer 1, [1] layer 2
//   mac_clr      - accumulator clears, same mapping as mac_en
//   l2_src_addr  - layer-2 source: 0 = bias, k = hidden neuron k-1
//   busy, done   - run in progress / one-cycle completion pulse
module ctrl_relu_fix #(
    parameter int ADDR_WIDTH = 16,
    parameter int N_IN       = 784,
    parameter int N_H        = 25,
    parameter int N_OUT      = 10,
    parameter int IMG_BASE   = 0,
    parameter int W1_BASE    = 1024,
    parameter int W2_BASE    = 20736,
    parameter int SKIP_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  arg_zero,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic [2:0]            r_sh_en,
    output logic [1:0]            mac_en,
    output logic [1:0]            mac_clr,
    output logic [ADDR_WIDTH-1:0] l2_src_addr,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = ADDR_WIDTH;
    localparam int IW = (N_IN + 1 > 1) ? $clog2(N_IN + 1) : 1;
    localparam int JW = (N_H > 1) ? $clog2(N_H) : 1;
    localparam int KW = (N_H + 1 > 1) ? $clog2(N_H + 1) : 1;
    localparam int MW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [AW-1:0] A_IMG  = AW'(IMG_BASE);
    localparam logic [AW-1:0] A_W1   = AW'(W1_BASE);
    localparam logic [AW-1:0] A_W2   = AW'(W2_BASE);
    localparam logic [AW-1:0] A_NH   = AW'(N_H);
    localparam logic [AW-1:0] A_NOUT = AW'(N_OUT);
    localparam logic [AW-1:0] A_ONE  = AW'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_L1_ARG,
        S_L1_LD,
        S_L1_CHK,
        S_L1_W,
        S_L1_TAIL,
        S_L1_MAC,
        S_L2_W,
        S_L2_TAIL,
        S_L2_MAC,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_i;
    logic [JW-1:0]   r_j;
    logic [KW-1:0]   r_k;
    logic [MW-1:0]   r_m;
    logic [AW-1:0]   r_w1_ptr;
    logic [AW-1:0]   r_w2_ptr;
    // Which register the outstanding read targets; becomes r_sh_en
    // one cycle later, when the memory data is valid.
    logic [2:0]      r_rd_sel;

    logic w_skip;
    logic w_adv;
    logic w_last_in;

    assign w_skip    = (SKIP_ZERO != 0) && arg_zero;
    assign w_last_in = (r_i == IW'(N_IN));
    // An input is finished either by its MAC or by being skipped.
    assign w_adv     = (r_state == S_L1_MAC) ||
                       ((r_state == S_L1_CHK) && w_skip);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_m         <= '0;
            r_w1_ptr    <= '0;
            r_w2_ptr    <= '0;
            r_rd_sel    <= '0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            r_sh_en     <= '0;
            mac_en      <= '0;
            mac_clr     <= '0;
            l2_src_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_rd      <= 1'b0;
            r_rd_sel    <= '0;
            r_sh_en     <= r_rd_sel;
            mac_en      <= '0;
            mac_clr     <= '0;
            done        <= 1'b0;
            l2_src_addr <= '0;

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CLR;
                        mac_clr <= 2'b11;
                        busy    <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_i      <= '0;
                    r_w1_ptr <= A_W1;
                    mem_addr <= A_IMG;
                    mem_rd   <= 1'b1;
                    r_rd_sel <= 3'b001;
                    r_state  <= S_L1_ARG;
                end
                S_L1_ARG: r_state <= S_L1_LD;
                S_L1_LD:  r_state <= S_L1_CHK;
                S_L1_CHK: begin
                    if (!w_skip) begin
                        r_j      <= '0;
                        mem_addr <= r_w1_ptr;
                        mem_rd   <= 1'b1;
                        r_rd_sel <= 3'b010;
                        r_state  <= S_L1_W;
                    end
                end
                S_L1_W: begin
                    if (r_j == JW'(N_H - 1)) begin
                        r_state <= S_L1_TAIL;
                    end else begin
                        r_j      <= r_j + JW'(1);
                        mem_addr <= mem_addr + A_ONE;
                        mem_rd   <= 1'b1;
                        r_rd_sel <= 3'b010;
                    end
                end
                S_L1_TAIL: begin
                    mac_en  <= 2'b01;
                    r_state <= S_L1_MAC;
                end
                S_L1_MAC: begin
                end
                S_L2_W: begin
                    l2_src_addr <= AW'(r_k);
                    if (r_m == MW'(N_OUT - 1)) begin
                        r_state <= S_L2_TAIL;
                    end else begin
                        r_m      <= r_m + MW'(1);
                        mem_addr <= mem_addr + A_ONE;
                        mem_rd   <= 1'b1;
                        r_rd_sel <= 3'b100;
                    end
                end
                S_L2_TAIL: begin
                    l2_src_addr <= AW'(r_k);
                    mac_en      <= 2'b10;
                    r_state     <= S_L2_MAC;
                end
                S_L2_MAC: begin
                    r_w2_ptr <= r_w2_ptr + A_NOUT;
                    if (r_k == KW'(N_H)) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_k         <= r_k + KW'(1);
                        r_m         <= '0;
                        mem_addr    <= r_w2_ptr + A_NOUT;
                        mem_rd      <= 1'b1;
                        r_rd_sel    <= 3'b100;
                        l2_src_addr <= AW'(r_k) + A_ONE;
                        r_state     <= S_L2_W;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Shared end-of-input step for both the MAC and skip paths.
            if (w_adv) begin
                r_w1_ptr <= r_w1_ptr + A_NH;
                if (w_last_in) begin
                    r_k      <= '0;
                    r_m      <= '0;
                    r_w2_ptr <= A_W2;
                    mem_addr <= A_W2;
                    mem_rd   <= 1'b1;
                    r_rd_sel <= 3'b100;
                    r_state  <= S_L2_W;
                end else begin
                    r_i      <= r_i + IW'(1);
                    mem_addr <= A_IMG + AW'(r_i) + A_ONE;
                    mem_rd   <= 1'b1;
                    r_rd_sel <= 3'b001;
                    r_state  <= S_L1_ARG;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctrl_relu_fix.sv
// tb_ctrl_relu_fix: directed bench for ctrl_relu_fix (skip and no-skip builds).
// Ports: none; drives both DUT instances from a shared clock and reset.
module tb_ctrl_relu_fix;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic use0 = 1'b0;
    int   mode = 0;

    always #5 clk = ~clk;

    logic          st1, az1, rd1, bz1, dn1;
    logic [AW-1:0] ad1, l2s1;
    logic [2:0]    sh1;
    logic [1:0]    me1, mc1;
    logic          st0, az0, rd0, bz0, dn0;
    logic [AW-1:0] ad0, l2s0;
    logic [2:0]    sh0;
    logic [1:0]    me0, mc0;

    assign st1 = use0 ? 1'b0 : start;
    assign st0 = use0 ? start : 1'b0;

    ctrl_relu_fix #(.SKIP_ZERO(1)) u_dut (
        .clk(clk), .rst(rst), .start(st1), .arg_zero(az1),
        .mem_addr(ad1), .mem_rd(rd1), .r_sh_en(sh1), .mac_en(me1),
        .mac_clr(mc1), .l2_src_addr(l2s1), .busy(bz1), .done(dn1)
    );

    ctrl_relu_fix #(.SKIP_ZERO(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(st0), .arg_zero(az0),
        .mem_addr(ad0), .mem_rd(rd0), .r_sh_en(sh0), .mac_en(me0),
        .mac_clr(mc0), .l2_src_addr(l2s0), .busy(bz0), .done(dn0)
    );

    // Image contents per test mode; weights are arbitrary nonzero.
    function automatic logic [15:0] word(int md, logic [AW-1:0] a);
        if (a > 16'd784) return 16'h0001;
        case (md)
            0: return (a == 0) ? 16'h0001 : 16'h0000;
            1: return a + 16'h0001;
            2: return 16'h0000;
            default: return (a == 0 || a == 3) ? 16'h0001 : 16'h0000;
        endcase
    endfunction

    logic [15:0] rdat1 = 16'hFFFF, arg1 = 16'hFFFF;
    logic [15:0] rdat0 = 16'hFFFF, arg0 = 16'hFFFF;
    always @(posedge clk) begin
        if (rd1) rdat1 <= word(mode, ad1);
        if (sh1[0]) arg1 <= rdat1;
        if (rd0) rdat0 <= word(mode, ad0);
        if (sh0[0]) arg0 <= rdat0;
    end
    assign az1 = (arg1 == 16'h0000);
    assign az0 = (arg0 == 16'h0000);

    logic          o_rd, o_bz, o_dn;
    logic [AW-1:0] o_ad, o_l2s;
    logic [2:0]    o_sh;
    logic [1:0]    o_me, o_mc;
    assign o_rd  = use0 ? rd0 : rd1;
    assign o_bz  = use0 ? bz0 : bz1;
    assign o_dn  = use0 ? dn0 : dn1;
    assign o_ad  = use0 ? ad0 : ad1;
    assign o_l2s = use0 ? l2s0 : l2s1;
    assign o_sh  = use0 ? sh0 : sh1;
    assign o_me  = use0 ? me0 : me1;
    assign o_mc  = use0 ? mc0 : mc1;

    int n_busy = 0, n_m0 = 0, n_m1 = 0, n_clr = 0, n_done = 0, n_viol = 0;
    always @(posedge clk) begin
        if (o_bz) n_busy++;
        if (o_me[0]) n_m0++;
        if (o_me[1]) n_m1++;
        if (o_mc != 2'b00) n_clr++;
        if (o_dn) n_done++;
        if ((o_me[0] && o_sh[1]) || (o_me[1] && o_sh[2]) ||
            (o_mc != 2'b00 && o_me != 2'b00)) n_viol++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 30000; n++) begin
            @(negedge clk);
            if (o_dn) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int md;
        bit u0;
        int busy;
        int m0;
        int m1;
        int clr;
    } vec_t;

    vec_t tbl[4];
    int b_s, m0_s, m1_s, c_s, d_s, v_s;
    bit seen;
    int err, k, m, last_src;
    bit found;

    task automatic snap();
        b_s = n_busy; m0_s = n_m0; m1_s = n_m1;
        c_s = n_clr; d_s = n_done; v_s = n_viol;
    endtask

    initial begin
        tbl[0] = '{0, 1'b0, 2695, 1, 26, 1};
        tbl[1] = '{1, 1'b0, 23863, 785, 26, 1};
        tbl[2] = '{2, 1'b1, 23863, 785, 26, 1};
        tbl[3] = '{3, 1'b0, 2722, 2, 26, 1};

        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("reset_outs_skip",
            longint'({ad1, rd1, sh1, me1, mc1, l2s1, bz1, dn1}), 0);
        chk("reset_outs_noskip",
            longint'({ad0, rd0, sh0, me0, mc0, l2s0, bz0, dn0}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Async reset in the middle of a weight burst
        use0 = 1'b0;
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (o_rd && o_ad >= 16'd1024) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("find_l1w", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs",
            longint'({o_ad, o_rd, o_sh, o_me, o_mc, o_l2s, o_bz, o_dn}), 0);
        mode = 0;
        @(negedge clk);
        snap();
        rst = 1'b0;
        start = 1'b1;
        wait_done(seen);
        chk("rst_run_done_seen", seen, 1);
        @(negedge clk);
        chk("rst_run_busy", n_busy - b_s, 2695);
        chk("rst_run_done_cnt", n_done - d_s, 1);
        chk("idle_gap", {o_bz, o_dn}, 0);
        @(negedge clk);
        chk("restart_busy", o_bz, 1);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table of full runs, each with an ignored mid-run start
        for (int t = 0; t < 4; t++) begin
            mode = tbl[t].md;
            use0 = tbl[t].u0;
            @(negedge clk);
            snap();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (50) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(seen);
            @(negedge clk);
            chk($sformatf("t%0d_done_seen", t), seen, 1);
            chk($sformatf("t%0d_busy", t), n_busy - b_s, tbl[t].busy);
            chk($sformatf("t%0d_mac0", t), n_m0 - m0_s, tbl[t].m0);
            chk($sformatf("t%0d_mac1", t), n_m1 - m1_s, tbl[t].m1);
            chk($sformatf("t%0d_clr", t), n_clr - c_s, tbl[t].clr);
            chk($sformatf("t%0d_done_cnt", t), n_done - d_s, 1);
            chk($sformatf("t%0d_overlap", t), n_viol - v_s, 0);
        end

        // Read trace around pixel 3 and through layer 2
        use0 = 1'b0;
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (o_rd && o_ad == 16'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("img3_read", found, 1);
        @(negedge clk);
        for (int n = 0; n < 10 && !o_rd; n++) @(negedge clk);
        chk("w1_row3_first", o_ad, 1099);
        err = 0;
        for (int j = 0; j < 25; j++) begin
            if (!o_rd || o_ad != 16'(1099 + j) ||
                o_sh[1] != (j != 0) || o_me != 2'b00 || o_l2s != 0)
                err++;
            @(negedge clk);
        end
        if (o_rd || !o_sh[1] || o_me != 2'b00) err++;
        @(negedge clk);
        if (o_me != 2'b01 || o_sh[1]) err++;
        chk("l1_row3_trace", err, 0);

        k = 0;
        m = 0;
        err = 0;
        last_src = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (o_dn) break;
            if (o_rd && o_ad >= 16'd20736) begin
                if (o_ad != 16'(20736 + k * 10 + m) || o_l2s != 16'(k)) err++;
                m++;
            end
            if (o_me[1]) begin
                last_src = int'(o_l2s);
                if (o_l2s != 16'(k) || m != 10) err++;
                k++;
                m = 0;
            end
        end
        chk("l2_done", o_dn, 1);
        chk("l2_macs", k, 26);
        chk("l2_last_src", last_src, 25);
        chk("l2_trace", err, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
